// File: rtl/conv_layer_mem.sv
// conv_layer_mem: on-chip memory responder for the convolution engine.
// Holds a 64x64 image (row-major, address {row,col}), a 4096-word layer-0
// result memory and a 1024-word layer-1 result memory. The block loads the
// image over a valid/ready stream, hands it to the engine, serves the
// engine's layer reads/writes while it is busy, then streams both layers out.
// Optional protocol checking is enabled with `define CONV_LAYER_MEM_ERR_CHECK_EN.
module conv_layer_mem #(
  parameter int DW     = 20,
  parameter int IMG_AW = 12,
  parameter int L1_AW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  // image load stream
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DW-1:0]     ld_data,
  // engine handshake
  output logic              ready,
  input  logic              busy,
  // engine image read port
  input  logic [IMG_AW-1:0] iaddr,
  output logic [DW-1:0]     idata,
  // engine layer write port
  input  logic              cwr,
  input  logic [IMG_AW-1:0] caddr_wr,
  input  logic [DW-1:0]     cdata_wr,
  // engine layer read port
  input  logic              crd,
  input  logic [IMG_AW-1:0] caddr_rd,
  output logic [DW-1:0]     cdata_rd,
  input  logic [2:0]        csel,
  // result dump stream
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DW-1:0]     dump_data,
  output logic              dump_sel,
  output logic              done,
  output logic              err
);

  localparam int IMG_WORDS = 1 << IMG_AW;
  localparam int L1_WORDS  = 1 << L1_AW;

  localparam logic [2:0] S_LOAD    = 3'd0;
  localparam logic [2:0] S_READY   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_DUMP_L0 = 3'd3;
  localparam logic [2:0] S_DUMP_L1 = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [2:0] SEL_L0 = 3'b001;
  localparam logic [2:0] SEL_L1 = 3'b011;

  localparam logic [IMG_AW-1:0] CNT_ONE      = IMG_AW'(1);
  localparam logic [IMG_AW-1:0] CNT_IMG_LAST = IMG_AW'(IMG_WORDS - 1);
  localparam logic [IMG_AW-1:0] CNT_L1_LAST  = IMG_AW'(L1_WORDS - 1);

  // storage arrays, deliberately never cleared by reset
  logic [DW-1:0] imageMem [0:IMG_WORDS-1];
  logic [DW-1:0] l0Mem    [0:IMG_WORDS-1];
  logic [DW-1:0] l1Mem    [0:L1_WORDS-1];

  logic [2:0]        state_q, state_d;
  logic [IMG_AW-1:0] cnt_q, cnt_d;
  logic [IMG_AW-1:0] cntNext;
  logic [DW-1:0]     dumpData_q, dumpData_d;
  logic              ldReady_q, ready_q, dumpValid_q, dumpSel_q, done_q;

  logic ldFire;
  logic dumpFire;
  logic inRun;
  logic l0Wr;
  logic l1Wr;

  assign ldFire   = ld_valid && ldReady_q;
  assign dumpFire = dumpValid_q && dump_ready;
  assign inRun    = (state_q == S_RUN);
  assign cntNext  = cnt_q + CNT_ONE;
  assign l0Wr     = inRun && cwr && (csel == SEL_L0);
  assign l1Wr     = inRun && cwr && (csel == SEL_L1);

  // Next-state, counter and dump word selection. The dump register is
  // preloaded with the next word at every handshake so the stream can move
  // one word per cycle, including across the layer-0 to layer-1 boundary.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dumpData_d = dumpData_q;
    case (state_q)
      S_LOAD: begin
        if (ldFire) begin
          if (cnt_q == CNT_IMG_LAST) begin
            cnt_d   = '0;
            state_d = S_READY;
          end else begin
            cnt_d = cntNext;
          end
        end
      end
      S_READY: begin
        if (busy) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!busy) begin
          cnt_d      = '0;
          state_d    = S_DUMP_L0;
          dumpData_d = l0Mem[0];
        end
      end
      S_DUMP_L0: begin
        if (dumpFire) begin
          if (cnt_q == CNT_IMG_LAST) begin
            cnt_d      = '0;
            state_d    = S_DUMP_L1;
            dumpData_d = l1Mem[0];
          end else begin
            cnt_d      = cntNext;
            dumpData_d = l0Mem[cntNext];
          end
        end
      end
      S_DUMP_L1: begin
        if (dumpFire) begin
          if (cnt_q == CNT_L1_LAST) begin
            cnt_d      = '0;
            state_d    = S_DONE;
            dumpData_d = '0;
          end else begin
            cnt_d      = cntNext;
            dumpData_d = l1Mem[cntNext[L1_AW-1:0]];
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered status outputs; outputs follow the next
  // state so they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      dumpData_q  <= '0;
      ldReady_q   <= 1'b1;
      ready_q     <= 1'b0;
      dumpValid_q <= 1'b0;
      dumpSel_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dumpData_q  <= dumpData_d;
      ldReady_q   <= (state_d == S_LOAD);
      ready_q     <= (state_d == S_READY);
      dumpValid_q <= (state_d == S_DUMP_L0) || (state_d == S_DUMP_L1);
      dumpSel_q   <= (state_d == S_DUMP_L1);
      done_q      <= (state_d == S_DONE);
    end
  end

  // Image capture during the load phase, written in address order.
  always_ff @(posedge clk) begin
    if (!reset && ldFire && (state_q == S_LOAD)) begin
      imageMem[cnt_q] <= ld_data;
    end
  end

  // Layer-0 writes from the engine, only while it is running.
  always_ff @(posedge clk) begin
    if (!reset && l0Wr) begin
      l0Mem[caddr_wr] <= cdata_wr;
    end
  end

  // Layer-1 writes from the engine; only the low address bits index it.
  always_ff @(posedge clk) begin
    if (!reset && l1Wr) begin
      l1Mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
    end
  end

  // Layer read mux: asynchronous, so a same-cycle write is not yet visible.
  always_comb begin
    cdata_rd = '0;
    if (inRun && crd) begin
      case (csel)
        SEL_L0:  cdata_rd = l0Mem[caddr_rd];
        SEL_L1:  cdata_rd = l1Mem[caddr_rd[L1_AW-1:0]];
        default: cdata_rd = '0;
      endcase
    end
  end

  assign idata      = imageMem[iaddr];
  assign ld_ready   = ldReady_q;
  assign ready      = ready_q;
  assign dump_valid = dumpValid_q;
  assign dump_sel   = dumpSel_q;
  assign dump_data  = dumpData_q;
  assign done       = done_q;

`ifdef CONV_LAYER_MEM_ERR_CHECK_EN
  logic err_q;
  logic errHit;
  logic selValid;
  logic wrHighAddr;
  logic rdHighAddr;

  assign selValid   = (csel == SEL_L0) || (csel == SEL_L1);
  assign wrHighAddr = (caddr_wr[IMG_AW-1:L1_AW] != '0);
  assign rdHighAddr = (caddr_rd[IMG_AW-1:L1_AW] != '0);

  // Flag illegal engine accesses: simultaneous read/write, bad select,
  // out-of-range layer-1 address, or any access outside the run phase.
  always_comb begin
    errHit = 1'b0;
    if (cwr && crd) begin
      errHit = 1'b1;
    end
    if ((cwr || crd) && !selValid) begin
      errHit = 1'b1;
    end
    if ((csel == SEL_L1) && ((cwr && wrHighAddr) || (crd && rdHighAddr))) begin
      errHit = 1'b1;
    end
    if ((cwr || crd) && !inRun) begin
      errHit = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (errHit) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_layer_mem.sv
// tb_conv_layer_mem: directed, table-driven bench for conv_layer_mem.
module tb_conv_layer_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [19:0] ld_data;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [19:0] idata;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic [2:0]  csel;
  logic        dump_valid;
  logic        dump_ready;
  logic [19:0] dump_data;
  logic        dump_sel;
  logic        done;
  logic        err;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [19:0] l0Model [0:4095];
  logic [19:0] l1Model [0:1023];

  typedef struct {
    logic        cwr;
    logic        crd;
    logic [2:0]  csel;
    logic [11:0] waddr;
    logic [19:0] wdata;
    logic [11:0] raddr;
    logic [11:0] iaddr;
    logic [19:0] expIdata;
    logic [19:0] expRd;
  } vec_t;

  vec_t vecs [0:13];

  conv_layer_mem #(.DW(20), .IMG_AW(12), .L1_AW(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ready      (ready),
    .busy       (busy),
    .iaddr      (iaddr),
    .idata      (idata),
    .cwr        (cwr),
    .caddr_wr   (caddr_wr),
    .cdata_wr   (cdata_wr),
    .crd        (crd),
    .caddr_rd   (caddr_rd),
    .cdata_rd   (cdata_rd),
    .csel       (csel),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_sel   (dump_sel),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Global watchdog so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", totalChecks, badChecks);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [19:0] l0Fill(input int a);
    logic [11:0] a12;
    a12 = 12'(a);
    return {8'h3C, a12};
  endfunction

  function automatic logic [19:0] l1Fill(input int a);
    logic [9:0] a10;
    a10 = 10'(a);
    return {10'h2A5, a10};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Stream the image in (image[i] = i) and check the handover to READY.
  task automatic loadImage();
    int accepted = 0;
    int cyc = 0;
    ld_valid = 1'b1;
    while (accepted < 4096 && cyc < 5000) begin
      ld_data = 20'(accepted);
      #2;
      if (ld_ready) accepted++;
      tick();
      cyc++;
    end
    ld_valid = 1'b0;
    ld_data  = '0;
    checkOutput("loadCount", 32'(accepted), 32'd4096);
    #2;
    checkOutput("ldReadyLow", 32'(ld_ready), 32'd0);
    checkOutput("readyHigh", 32'(ready), 32'd1);
  endtask

  // Drive one RUN-phase vector, check the combinational outputs, then clock it.
  task automatic applyStimulus(input vec_t v, input int idx);
    cwr      = v.cwr;
    crd      = v.crd;
    csel     = v.csel;
    caddr_wr = v.waddr;
    cdata_wr = v.wdata;
    caddr_rd = v.raddr;
    iaddr    = v.iaddr;
    #2;
    checkOutput($sformatf("vec%0d idata", idx), 32'(idata), 32'(v.expIdata));
    checkOutput($sformatf("vec%0d cdata_rd", idx), 32'(cdata_rd), 32'(v.expRd));
    if (v.cwr && v.csel == 3'b001) l0Model[v.waddr] = v.wdata;
    if (v.cwr && v.csel == 3'b011) l1Model[v.waddr[9:0]] = v.wdata;
    tick();
  endtask

  // Consume nWords dump words, checking each cycle against the model.
  task automatic dumpWords(input int nWords, input bit toggle, output int cycles);
    int w = 0;
    int cyc = 0;
    logic [19:0] expData;
    logic expSel;
    while (w < nWords && cyc < 12000) begin
      dump_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      expData = (w < 4096) ? l0Model[w] : l1Model[w - 4096];
      expSel  = (w >= 4096);
      #2;
      checkOutput($sformatf("dumpValid w%0d", w), 32'(dump_valid), 32'd1);
      checkOutput($sformatf("dumpSel w%0d", w), 32'(dump_sel), 32'(expSel));
      checkOutput($sformatf("dumpData w%0d", w), 32'(dump_data), 32'(expData));
      if (dump_ready && dump_valid) w++;
      tick();
      cyc++;
    end
    dump_ready = 1'b0;
    checkOutput("dumpCount", 32'(w), 32'(nWords));
    cycles = cyc;
  endtask

  initial begin
    int cycles;
    vecs[0]  = '{1'b0, 1'b0, 3'b001, 12'h000, 20'h00000, 12'h000, 12'h041, 20'h00041, 20'h00000};
    vecs[1]  = '{1'b1, 1'b0, 3'b001, 12'h005, 20'h12345, 12'h000, 12'hFFF, 20'h00FFF, 20'h00000};
    vecs[2]  = '{1'b0, 1'b1, 3'b001, 12'h000, 20'h00000, 12'h005, 12'h000, 20'h00000, 20'h12345};
    vecs[3]  = '{1'b1, 1'b0, 3'b011, 12'h3FF, 20'hFFFFF, 12'h000, 12'h123, 20'h00123, 20'h00000};
    vecs[4]  = '{1'b0, 1'b1, 3'b001, 12'h000, 20'h00000, 12'h3FF, 12'h040, 20'h00040, 20'h3C3FF};
    vecs[5]  = '{1'b0, 1'b1, 3'b000, 12'h000, 20'h00000, 12'h3FF, 12'h041, 20'h00041, 20'h00000};
    vecs[6]  = '{1'b0, 1'b1, 3'b011, 12'h000, 20'h00000, 12'h3FF, 12'h800, 20'h00800, 20'hFFFFF};
    vecs[7]  = '{1'b0, 1'b0, 3'b011, 12'h000, 20'h00000, 12'h3FF, 12'h7FF, 20'h007FF, 20'h00000};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 12'h006, 20'hABCDE, 12'h000, 12'h001, 20'h00001, 20'h00000};
    vecs[9]  = '{1'b0, 1'b1, 3'b001, 12'h000, 20'h00000, 12'h006, 12'h002, 20'h00002, 20'h3C006};
    vecs[10] = '{1'b1, 1'b1, 3'b001, 12'h007, 20'h77777, 12'h007, 12'h003, 20'h00003, 20'h3C007};
    vecs[11] = '{1'b0, 1'b1, 3'b001, 12'h000, 20'h00000, 12'h007, 12'h004, 20'h00004, 20'h77777};
    vecs[12] = '{1'b1, 1'b0, 3'b011, 12'h005, 20'h0BEEF, 12'h000, 12'hABC, 20'h00ABC, 20'h00000};
    vecs[13] = '{1'b0, 1'b1, 3'b011, 12'h000, 20'h00000, 12'h405, 12'h555, 20'h00555, 20'h0BEEF};

    reset = 1'b1; ld_valid = 1'b0; ld_data = '0; busy = 1'b0; iaddr = '0;
    cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0; caddr_rd = '0;
    csel = 3'b000; dump_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #2;
    checkOutput("rstLdReady", 32'(ld_ready), 32'd1);
    checkOutput("rstReady", 32'(ready), 32'd0);
    checkOutput("rstDumpValid", 32'(dump_valid), 32'd0);
    checkOutput("rstDumpSel", 32'(dump_sel), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    checkOutput("rstDumpData", 32'(dump_data), 32'd0);
    tick();

    loadImage();
    for (int k = 0; k < 5; k++) begin
      tick();
      #2;
      checkOutput($sformatf("readyHold%0d", k), 32'(ready), 32'd1);
    end
    busy = 1'b1;
    tick();
    #2;
    checkOutput("readyDrop", 32'(ready), 32'd0);
    tick();

    for (int a = 0; a < 4096; a++) begin
      cwr = 1'b1; csel = 3'b001; caddr_wr = 12'(a); cdata_wr = l0Fill(a);
      l0Model[a] = l0Fill(a);
      tick();
    end
    for (int a = 0; a < 1024; a++) begin
      cwr = 1'b1; csel = 3'b011; caddr_wr = 12'(a); cdata_wr = l1Fill(a);
      l1Model[a] = l1Fill(a);
      tick();
    end
    cwr = 1'b0;
    #2;
    checkOutput("errAfterFill", 32'(err), 32'd0);
    tick();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], i);
    end
    cwr = 1'b0; crd = 1'b0; csel = 3'b000; busy = 1'b0;
    #2;
`ifdef CONV_LAYER_MEM_ERR_CHECK_EN
    checkOutput("errSticky", 32'(err), 32'd1);
`else
    checkOutput("errTiedLow", 32'(err), 32'd0);
`endif
    tick();

    dumpWords(5120, 1'b1, cycles);
    #2;
    checkOutput("doneHigh", 32'(done), 32'd1);
    checkOutput("doneValidLow", 32'(dump_valid), 32'd0);
    tick();
    tick();
    #2;
    checkOutput("doneStuck", 32'(done), 32'd1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    checkOutput("rst2Done", 32'(done), 32'd0);
    tick();
    loadImage();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    dumpWords(100, 1'b0, cycles);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    checkOutput("midRstLdReady", 32'(ld_ready), 32'd1);
    checkOutput("midRstDumpValid", 32'(dump_valid), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstDumpData", 32'(dump_data), 32'd0);
    checkOutput("midRstErr", 32'(err), 32'd0);
    tick();

    loadImage();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    dumpWords(5120, 1'b0, cycles);
    checkOutput("backToBackCycles", 32'(cycles), 32'd5120);
    #2;
    checkOutput("rerunDone", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/conv_layer_mem.md
Name: conv_layer_mem

Overview:
- Memory-side responder for the convolution engine's image and layer-memory interface.
- Holds a 4096x20 image memory (64x64, row-major, address {row,col}), a 4096x20 layer-0 memory and a 1024x20 layer-1 memory.
- Phases: accepts an image over a load stream, raises `ready`, serves engine reads/writes while `busy`, then streams layer-0 and layer-1 results out over a dump stream.
- Replaces the behavioural memory model, so the engine can be driven from on-chip logic.

Parameters:
- DW, 20, pixel/result data width (signed)
- IMG_AW, 12, image and layer-0 address width (4096 words)
- L1_AW, 10, layer-1 address width (1024 words)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- ld_valid  in  1  load word valid
- ld_ready  out  1  load word accepted when ld_valid&&ld_ready
- ld_data  in  DW  image pixel, loaded in address order 0..4095
- ready  out  1  to engine: image loaded, start
- busy  in  1  from engine: processing
- iaddr  in  IMG_AW  image read address
- idata  out  DW  image data
- cwr  in  1  layer write strobe
- caddr_wr  in  IMG_AW  layer write address
- cdata_wr  in  DW  layer write data
- crd  in  1  layer read strobe
- caddr_rd  in  IMG_AW  layer read address
- cdata_rd  out  DW  layer read data
- csel  in  3  layer select: 3'b001=L0, 3'b011=L1, others=none
- dump_valid  out  1  result word valid
- dump_ready  in  1  sink accepts when dump_valid&&dump_ready
- dump_data  out  DW  result word
- dump_sel  out  1  0=L0 word, 1=L1 word
- done  out  1  all results dumped
- err  out  1  protocol error flag (optional feature)

Behaviour:
- Reset values:
  - state LOAD; counter 0.
  - ld_ready=1; ready, dump_valid, dump_sel, done, err = 0.
  - dump_data=0.
  - Memory arrays are NOT cleared.
- Reset mid-operation aborts any phase and returns to LOAD on the next cycle.
- States: LOAD, READY, RUN, DUMP_L0, DUMP_L1, DONE.
- LOAD:
  - ld_ready=1.
  - On each handshake: image[cnt] <= ld_data, cnt++.
  - Handshake at cnt==4095: cnt <= 0, go to READY. ld_ready=0 from that cycle on.
- READY:
  - ready=1, held until busy sampled 1, then RUN.
  - ready is a registered output; it goes 0 the cycle RUN is entered.
- RUN:
  - idata = image[iaddr], combinational, zero latency, valid in every state.
  - Write: cwr=1 at a rising edge writes cdata_wr into L0[caddr_wr] (csel=001) or L1[caddr_wr[L1_AW-1:0]] (csel=011). Any other csel is ignored.
  - Read: cdata_rd is combinational from the selected memory at caddr_rd when crd=1. Otherwise 0, and 0 for any other csel.
  - A write and a read of the same address in one cycle return the old data.
  - busy sampled 0 in RUN: cnt <= 0, go to DUMP_L0.
- DUMP_L0:
  - dump_valid=1, dump_sel=0, dump_data=L0[cnt] (registered).
  - dump_data is held stable until the handshake; cnt++ per handshake.
  - Handshake at cnt==4095: cnt <= 0, go to DUMP_L1.
- DUMP_L1:
  - Same as DUMP_L0 with dump_sel=1 and data from L1.
  - Handshake at cnt==1023: go to DONE.
- DONE: done=1, dump_valid=0. Sticky until reset.
- The dump stream is back-to-back capable: one word per cycle when dump_ready is held 1. The DUMP_L0->DUMP_L1 transition inserts no bubble.
- Signals from the engine are ignored outside RUN, except in the error checks below.

Optional Feature:
- Macro: CONV_LAYER_MEM_ERR_CHECK_EN
- Defined: err is set to 1 (sticky until reset) on any of:
  - cwr&&crd in the same cycle;
  - cwr or crd with csel not in {001, 011};
  - csel=011 with caddr_wr or caddr_rd >= 1024 while cwr/crd is active;
  - cwr or crd outside RUN.
- err rises the cycle after the offending edge.
- Not defined: err is tied 0 and no check logic is present.

Test Plan:
- Load image[i]=i (i=0..4095) with ld_valid held 1 -> ld_ready drops after 4096 accepts. ready=1 one cycle later and holds through 5 cycles with busy=0.
- In RUN, iaddr=12'h041 -> idata=20'h00041 in the same cycle. Write cwr, csel=001, caddr_wr=5, data=20'h12345, then crd, caddr_rd=5 -> cdata_rd=20'h12345.
- Write L1[1023]=20'hFFFFF via csel=011. Then read with csel=001 at 1023 -> the L0 value, not FFFFF. Read with csel=000 -> 0.
- busy falls, dump_ready toggled 1/0 every cycle -> 4096 words with dump_sel=0 in address order, data stable while stalled. Then 1024 words with dump_sel=1, including word 1023=20'hFFFFF. done=1 after the last handshake.
- Assert reset for 1 cycle mid DUMP_L0 (after 100 words) -> next cycle state LOAD, ld_ready=1, dump_valid=0, done=0. Reloading and rerunning yields the same dump.
- With CONV_LAYER_MEM_ERR_CHECK_EN defined: cwr=1 and crd=1 together in RUN -> err=1 next cycle and stays 1. Without the macro: err=0 throughout.
